fir_requant_decim: RTL and testbench

// - Output stage directly downstream of the FIR filter.
// - Takes the full-width signed FIR result (one sample per clk while in_valid).
// - Decimates by DECIM, rounds and arithmetic-shifts by SHIFT, then saturates to OWIDTH.
// - Buffers results in a DEPTH-entry FIFO behind a valid/ready output port.

---
 rtl/fir_requant_decim_pkg.sv | 22 ++
 rtl/fir_requant_decim_if.sv | 14 +
 rtl/fir_requant_decim_sync_fifo.sv | 53 +++++
 rtl/fir_requant_decim.sv | 111 +++++++++++
 tb/tb_fir_requant_decim.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_requant_decim_pkg.sv
// Shared helpers for the FIR output requantiser: ceiling log2 and the
// signed output range used for saturation.
package fir_requant_decim_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_requant_decim_if.sv
// Sample-in / requantised-sample-out handshake bundle of the FIR output stage.
interface fir_requant_decim_if #(
  parameter int IWIDTH = 47,
  parameter int OWIDTH = 16
);
  logic                     in_valid;
  logic signed [IWIDTH-1:0] in;
  logic signed [OWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output in_valid, in, out_ready, input out_data, out_valid);
  modport slave  (input in_valid, in, out_ready, output out_data, out_valid);
endinterface

// File: rtl/fir_requant_decim_sync_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted only
// when a read frees a slot on the same edge.
module fir_requant_decim_sync_fifo
  import fir_requant_decim_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_level
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic             w_rd;
  logic             w_wr;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign o_level   = r_wr_cnt - r_rd_cnt;
  assign o_empty   = (o_level == '0);
  assign o_full    = (o_level == (AW+1)'(DEPTH));
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (i_clr) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr) r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
      if (w_rd) r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !i_clr) r_mem[r_wr_cnt[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/fir_requant_decim.sv
// FIR output stage: keep 1 of DECIM samples, round-half-up and shift by SHIFT,
// saturate to OWIDTH and queue the result behind a valid/ready port.
module fir_requant_decim
  import fir_requant_decim_pkg::*;
#(
  parameter int IWIDTH = 47,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  fir_requant_decim_if.slave    bus,
  output logic                  sat,
  output logic                  ovf,
  output logic [clog2(DEPTH):0] level
);
  localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam int XW   = IWIDTH + 1;
  localparam logic signed [XW-1:0] OMAX = XW'(sat_hi(OWIDTH));
  localparam logic signed [XW-1:0] OMIN = XW'(sat_lo(OWIDTH));
  localparam logic signed [XW-1:0] RND  =
    (SHIFT > 0) ? XW'(longint'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [XW-1:0] round_shift(input logic signed [IWIDTH-1:0] x);
    logic signed [XW-1:0] ext;
    ext = {x[IWIDTH-1], x};
    return (ext + RND) >>> SHIFT;
  endfunction

  function automatic logic clipped(input logic signed [XW-1:0] x);
    return (x > OMAX) || (x < OMIN);
  endfunction

  function automatic logic signed [OWIDTH-1:0] saturate(input logic signed [XW-1:0] x);
    if (x > OMAX) return OMAX[OWIDTH-1:0];
    if (x < OMIN) return OMIN[OWIDTH-1:0];
    return x[OWIDTH-1:0];
  endfunction

  logic [PH_W-1:0]          r_phase;
  logic                     r_vld_p0;
  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic signed [IWIDTH-1:0] r_in_p0;
  logic signed [XW-1:0]     r_rnd_p1;
  logic signed [OWIDTH-1:0] r_q_p2;
  logic                     w_sel;
  logic                     w_rd;
  logic                     w_full;
  logic                     w_empty;

  assign w_sel = bus.in_valid && (r_phase == PH_W'(DECIM - 1));
  assign w_rd  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= '0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      sat      <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr) begin
      r_phase  <= '0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      sat      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (bus.in_valid) r_phase <= w_sel ? '0 : r_phase + PH_W'(1);
      r_vld_p0 <= w_sel;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1 && clipped(r_rnd_p1)) sat <= 1'b1;
      if (r_vld_p2 && w_full && !w_rd)   ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // p0: capture selected sample
    if (w_sel) r_in_p0 <= bus.in;
    // p1: round and shift
    r_rnd_p1 <= round_shift(r_in_p0);
    // p2: saturate, FIFO write on the next edge
    r_q_p2   <= saturate(r_rnd_p1);
  end

  fir_requant_decim_sync_fifo #(
    .WIDTH (OWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (clr),
    .i_wr_en   (r_vld_p2),
    .i_wr_data (r_q_p2),
    .i_rd_en   (bus.out_ready),
    .o_rd_data (bus.out_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  assign bus.out_valid = !w_empty;

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: random and directed stimulus against a queue-based
// reference of decimation, rounding, saturation and FIFO behaviour.
module tb_fir_requant_decim;
  localparam int IW  = 47;
  localparam int OW  = 16;
  localparam int SH  = 16;
  localparam int DEC = 4;
  localparam int DEP = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr   = 1'b0;
  logic       clr1  = 1'b0;
  logic       sat, ovf, sat1, ovf1;
  logic [3:0] level, level1;

  fir_requant_decim_if #(.IWIDTH(IW), .OWIDTH(OW)) bus  ();
  fir_requant_decim_if #(.IWIDTH(IW), .OWIDTH(OW)) bus1 ();

  always #5 clk = ~clk;

  fir_requant_decim #(.IWIDTH(IW), .OWIDTH(OW), .SHIFT(SH), .DECIM(DEC), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus), .sat(sat), .ovf(ovf), .level(level));

  fir_requant_decim #(.IWIDTH(IW), .OWIDTH(OW), .SHIFT(SH), .DECIM(1), .DEPTH(DEP)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(bus1), .sat(sat1), .ovf(ovf1), .level(level1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference state: FIFO contents, samples in flight with their write cycle.
  int     m_fifo[$];
  longint p_val[$];
  int     p_due[$];
  bit     p_clip[$];
  int     m_phase = 0;
  int     cyc = 0;
  bit     m_sat = 0;
  bit     m_ovf = 0;
  int     got[$];

  function automatic int requant(input longint x, output bit clip);
    longint d, s, q;
    d = longint'(1) <<< SH;
    s = x + d / 2;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    clip = 1'b0;
    if (q > 32767)  begin q = 32767;  clip = 1'b1; end
    if (q < -32768) begin q = -32768; clip = 1'b1; end
    return int'(q);
  endfunction

  task automatic model_reset();
    m_fifo.delete(); p_val.delete(); p_due.delete(); p_clip.delete();
    m_phase = 0; m_sat = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit v, input longint x, input bit rdy, input bit c);
    bit rd, full, clip;
    int q;
    cyc++;
    if (c) begin
      model_reset();
      return;
    end
    full = (m_fifo.size() == DEP);
    rd   = (m_fifo.size() > 0) && rdy;
    foreach (p_due[i]) if (p_due[i] == cyc + 1 && p_clip[i]) m_sat = 1;
    if (rd) void'(m_fifo.pop_front());
    if (p_due.size() > 0 && p_due[0] == cyc) begin
      if (full && !rd) m_ovf = 1;
      else m_fifo.push_back(int'(p_val[0]));
      void'(p_due.pop_front()); void'(p_val.pop_front()); void'(p_clip.pop_front());
    end
    if (v) begin
      m_phase++;
      if (m_phase == DEC) begin
        m_phase = 0;
        q = requant(x, clip);
        p_val.push_back(longint'(q));
        p_due.push_back(cyc + 3);
        p_clip.push_back(clip);
      end
    end
  endtask

  task automatic check_state();
    check("out_valid", longint'(bus.out_valid), longint'(m_fifo.size() > 0));
    check("out_data", longint'(bus.out_data), (m_fifo.size() > 0) ? longint'(m_fifo[0]) : 0);
    check("level", longint'(level), longint'(m_fifo.size()));
    check("sat", longint'(sat), longint'(m_sat));
    check("ovf", longint'(ovf), longint'(m_ovf));
  endtask

  task automatic drive(input bit v, input longint x, input bit rdy, input bit c);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in        = x[IW-1:0];
    bus.out_ready = rdy;
    clr           = c;
    #1;
    if (bus.out_valid && rdy && !c) got.push_back(int'(bus.out_data));
    model_edge(v, x, rdy, c);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    clr           = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1 check_state();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  function automatic longint rand_in();
    longint x;
    case ($urandom_range(0, 3))
      0: x = longint'($urandom_range(0, 2097151)) - 1048576;
      1: begin
        x = {$urandom(), $urandom()};
        x = (x <<< 17) >>> 17;
      end
      2: x = (longint'($urandom_range(0, 200)) - 100) * 65536 + 32768
             + longint'($urandom_range(0, 2)) - 1;
      default: x = (longint'($urandom_range(0, 4194304)) - 2097152) <<< 10;
    endcase
    return x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    bus.in_valid = 0; bus.in = '0; bus.out_ready = 0;
    bus1.in_valid = 0; bus1.in = '0; bus1.out_ready = 0;

    // Reset held with input activity
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in = 47'sd12345;
    model_reset();
    repeat (4) begin
      @(posedge clk);
      #1 check_state();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // Decimation: ramp in units of 2^16
    got.delete();
    for (int i = 0; i < 24; i++) drive(1, longint'(i) <<< 16, 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    check("dec_count", got.size(), 6);
    for (int k = 0; k < 3; k++) check("dec_value", (got.size() > k) ? got[k] : -1, 4 * k + 3);

    // Rounding boundaries
    drive(0, 0, 1, 1);
    got.delete();
    begin
      longint rv[4] = '{32768, 32767, -32768, -32769};
      int     re[4] = '{1, 0, 0, -1};
      for (int k = 0; k < 4; k++) begin
        repeat (3) drive(1, 0, 1, 0);
        drive(1, rv[k], 1, 0);
      end
      repeat (6) drive(0, 0, 1, 0);
      check("rnd_count", got.size(), 4);
      for (int k = 0; k < 4; k++) check("rnd_value", (got.size() > k) ? got[k] : 99, re[k]);
    end

    // Saturation and sticky sat
    drive(0, 0, 1, 1);
    got.delete();
    repeat (3) drive(1, 0, 1, 0);
    drive(1, longint'(1) <<< 40, 1, 0);
    repeat (3) drive(1, 0, 1, 0);
    drive(1, -(longint'(1) <<< 40), 1, 0);
    repeat (8) drive(0, 0, 1, 0);
    check("sat_pos", (got.size() > 0) ? got[0] : 0, 32767);
    check("sat_neg", (got.size() > 1) ? got[1] : 0, -32768);
    check("sat_sticky", longint'(sat), 1);
    drive(0, 0, 1, 1);
    check("sat_clr", longint'(sat), 0);

    // Randomised traffic with bursts of backpressure, sporadic clr and one reset
    for (int n = 0; n < 800; n++) begin
      bit rdy;
      if (n == 400) pulse_reset();
      rdy = ((n % 200) < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 9) < 7, rand_in(), rdy, $urandom_range(0, 99) == 0);
    end

    // Mid-stream clr: 3 queued, one in flight, phase non-zero
    drive(0, 0, 1, 1);
    for (int i = 0; i < 18; i++) drive(1, longint'(i) <<< 16, 0, 0);
    check("pre_clr_level", longint'(level), 3);
    drive(0, 0, 0, 1);
    check("clr_level", longint'(level), 0);
    check("clr_valid", longint'(bus.out_valid), 0);
    got.delete();
    for (int i = 100; i < 104; i++) drive(1, longint'(i) <<< 16, 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    check("clr_next", (got.size() > 0) ? got[0] : -1, 103);

    // Same sequence interrupted by an asynchronous reset pulse
    drive(0, 0, 1, 1);
    for (int i = 0; i < 18; i++) drive(1, longint'(i) <<< 16, 0, 0);
    check("pre_rst_level", longint'(level), 3);
    pulse_reset();
    check("rst_level", longint'(level), 0);
    check("rst_valid", longint'(bus.out_valid), 0);
    got.delete();
    for (int i = 200; i < 204; i++) drive(1, longint'(i) <<< 16, 1, 0);
    repeat (6) drive(0, 0, 1, 0);
    check("rst_next", (got.size() > 0) ? got[0] : -1, 203);

    // Backpressure on the DECIM=1 instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v = longint'(i) <<< 16;
      bus1.in_valid = 1'b1; bus1.in = v[IW-1:0]; bus1.out_ready = 1'b0;
    end
    repeat (5) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
    end
    check("bp_level", longint'(level1), 8);
    check("bp_ovf", longint'(ovf1), 1);
    check("bp_head", longint'(bus1.out_data), 0);
    for (int i = 10; i < 13; i++) begin
      @(negedge clk);
      v = longint'(i) <<< 16;
      bus1.in_valid = 1'b1; bus1.in = v[IW-1:0];
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = longint'(13 + k) <<< 16;
      bus1.in_valid = 1'b1; bus1.in = v[IW-1:0]; bus1.out_ready = 1'b1;
      #1 check("bp_order", longint'(bus1.out_data), k);
      @(posedge clk);
      #1;
      check("bp_full_level", longint'(level1), 8);
      check("bp_full_ovf", longint'(ovf1), 1);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
